// File: rtl/axi_err_slv_fsm.sv
// Terminating AXI error slave: accepts every request, drains write bursts and
// answers B and R with a fixed error response and burst-correct R beats.

package axi_err_pkg;
    localparam int unsigned IdWidth   = 4;
    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 64;
    localparam int unsigned UserWidth = 1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [5:0]           atop;
        logic [UserWidth-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
        logic                   last;
        logic [UserWidth-1:0]   user;
    } w_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [1:0]           resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] addr;
        logic [7:0]           len;
        logic [2:0]           size;
        logic [1:0]           burst;
        logic                 lock;
        logic [3:0]           cache;
        logic [2:0]           prot;
        logic [3:0]           qos;
        logic [3:0]           region;
        logic [UserWidth-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [DataWidth-1:0] data;
        logic [1:0]           resp;
        logic                 last;
        logic [UserWidth-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } resp_t;
endpackage

// Registered (non fall-through) FIFO with occupancy counter.
module axi_err_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr, rd_ptr;
    logic [CntW-1:0]  count;

    assign full  = (count == CntW'(Depth));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// R FSM states:
//   state  | meaning
//   R_IDLE | no burst in flight; load the next queued AR if one is waiting
//   R_SEND | driving R beats for id_q; cnt_q beats remain after the current one
module axi_err_slv_fsm #(
    parameter type         req_t    = axi_err_pkg::req_t,
    parameter type         resp_t   = axi_err_pkg::resp_t,
    parameter logic [1:0]  Resp     = 2'b11,
    parameter logic [63:0] RespData = 64'hCA11AB1EBADCAB1E,
    parameter int unsigned MaxTrans = 4
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  req_t  slv_req_i,
    output resp_t slv_resp_o
);
    localparam int unsigned IdW   = axi_err_pkg::IdWidth;
    localparam int unsigned DataW = axi_err_pkg::DataWidth;

    typedef enum logic {R_IDLE, R_SEND} r_state_e;

    r_state_e state_q, state_d;
    logic [IdW-1:0] id_q, id_d;
    logic [7:0]     cnt_q, cnt_d;

    logic           wfifo_full, wfifo_empty, wfifo_pop;
    logic [IdW-1:0] wfifo_rdata;
    logic           bfifo_full, bfifo_empty, bfifo_pop;
    logic [IdW-1:0] bfifo_rdata;
    logic           rfifo_full, rfifo_empty, rfifo_pop;
    logic [IdW+7:0] rfifo_rdata;

    logic aw_ready, w_ready, ar_ready;
    logic aw_hs, w_hs, ar_hs;
    logic b_valid, r_valid, r_last;

    assign aw_ready  = !wfifo_full;
    assign w_ready   = !wfifo_empty && !bfifo_full;
    assign ar_ready  = !rfifo_full;
    assign aw_hs     = slv_req_i.aw_valid && aw_ready;
    assign w_hs      = slv_req_i.w_valid && w_ready;
    assign ar_hs     = slv_req_i.ar_valid && ar_ready;
    assign wfifo_pop = w_hs && slv_req_i.w.last;
    assign b_valid   = !bfifo_empty;
    assign bfifo_pop = b_valid && slv_req_i.b_ready;

    axi_err_fifo #(.Width(IdW), .Depth(MaxTrans)) i_wfifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (aw_hs),
        .wdata (slv_req_i.aw.id),
        .pop   (wfifo_pop),
        .rdata (wfifo_rdata),
        .full  (wfifo_full),
        .empty (wfifo_empty)
    );

    // The write ID moves to the B queue only once its whole burst is consumed.
    axi_err_fifo #(.Width(IdW), .Depth(2)) i_bfifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (wfifo_pop),
        .wdata (wfifo_rdata),
        .pop   (bfifo_pop),
        .rdata (bfifo_rdata),
        .full  (bfifo_full),
        .empty (bfifo_empty)
    );

    axi_err_fifo #(.Width(IdW + 8), .Depth(MaxTrans)) i_rfifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (ar_hs),
        .wdata ({slv_req_i.ar.id, slv_req_i.ar.len}),
        .pop   (rfifo_pop),
        .rdata (rfifo_rdata),
        .full  (rfifo_full),
        .empty (rfifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= R_IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        rfifo_pop = 1'b0;
        r_valid   = 1'b0;
        r_last    = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (!rfifo_empty) begin
                    rfifo_pop = 1'b1;
                    id_d      = rfifo_rdata[IdW+7:8];
                    cnt_d     = rfifo_rdata[7:0];
                    state_d   = R_SEND;
                end
            end
            R_SEND: begin
                r_valid = 1'b1;
                r_last  = (cnt_q == 8'd0);
                if (slv_req_i.r_ready) begin
                    if (r_last) begin
                        state_d = R_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    // Payload fields stay zero whenever their valid is low.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = aw_ready;
        slv_resp_o.ar_ready = ar_ready;
        slv_resp_o.w_ready  = w_ready;
        slv_resp_o.b_valid  = b_valid;
        slv_resp_o.r_valid  = r_valid;
        if (b_valid) begin
            slv_resp_o.b.id   = bfifo_rdata;
            slv_resp_o.b.resp = Resp;
        end
        if (r_valid) begin
            slv_resp_o.r.id   = id_q;
            slv_resp_o.r.data = DataW'(RespData);
            slv_resp_o.r.resp = Resp;
            slv_resp_o.r.last = r_last;
        end
    end

    logic unused_req_fields;
    assign unused_req_fields = ^{slv_req_i.aw, slv_req_i.w, slv_req_i.ar};

    a_max_trans: assert property (@(posedge clk_i) MaxTrans >= 1);

    a_b_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (b_valid && !slv_req_i.b_ready) |=> (b_valid && $stable(slv_resp_o.b)));

    a_r_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (r_valid && !slv_req_i.r_ready) |=> (r_valid && $stable(slv_resp_o.r)));

    a_no_orphan_w: assert property (@(posedge clk_i) disable iff (!rst_ni)
        w_hs |-> !wfifo_empty);
endmodule

// File: tb/tb_axi_err_slv_fsm.sv
// Self-checking bench for axi_err_slv_fsm: directed scenarios plus random traffic,
// checked against a queue-based model of accepted transactions.

module tb_axi_err_slv_fsm;
    import axi_err_pkg::*;

    localparam int          MAXT      = 4;
    localparam logic [1:0]  RESP_CODE = 2'b11;
    localparam logic [63:0] ERR_DATA  = 64'hCA11AB1EBADCAB1E;

    logic  clk = 1'b0;
    logic  rst_n;
    req_t  req;
    resp_t resp;

    always #5 clk = ~clk;

    axi_err_slv_fsm #(
        .req_t   (req_t),
        .resp_t  (resp_t),
        .Resp    (RESP_CODE),
        .RespData(ERR_DATA),
        .MaxTrans(MAXT)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .slv_req_i (req),
        .slv_resp_o(resp)
    );

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               last;
    } rbeat_t;

    int checks   = 0;
    int failures = 0;

    // Model: AWs awaiting their last W, Bs owed, R beats owed (in order).
    logic [IdWidth-1:0] aw_q[$];
    logic [IdWidth-1:0] b_q[$];
    rbeat_t             r_q[$];
    int w_hs_cnt = 0;
    int r_hs_cnt = 0;
    int b_hs_cnt = 0;
    bit rand_rdy = 1'b0;
    bit r_stall_prev = 1'b0;
    rbeat_t r_prev;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        rbeat_t exp_beat;
        check("aw_ready", resp.aw_ready, aw_q.size() < MAXT);
        check("w_ready", resp.w_ready, (aw_q.size() > 0) && (b_q.size() < 2));
        check("b_valid", resp.b_valid, b_q.size() > 0);
        if (b_q.size() > 0) begin
            check("b_id", resp.b.id, b_q[0]);
            check("b_resp", resp.b.resp, RESP_CODE);
        end else begin
            check("b_idle_payload", {resp.b.id, resp.b.resp, resp.b.user}, 0);
        end
        if (r_stall_prev) begin
            check("r_stall_valid", resp.r_valid, 1);
            check("r_stall_id", resp.r.id, r_prev.id);
            check("r_stall_last", resp.r.last, r_prev.last);
        end
        if (resp.r_valid) begin
            check("r_data", resp.r.data, ERR_DATA);
            check("r_resp", resp.r.resp, RESP_CODE);
        end else begin
            check("r_idle_payload", (resp.r.data != 0) || (resp.r.id != 0) ||
                  resp.r.last || (resp.r.resp != 0), 0);
        end
        if (resp.r_valid && req.r_ready) begin
            r_hs_cnt++;
            check("r_expected", r_q.size() > 0, 1);
            if (r_q.size() > 0) begin
                exp_beat = r_q.pop_front();
                check("r_id", resp.r.id, exp_beat.id);
                check("r_last", resp.r.last, exp_beat.last);
            end
        end
        if (resp.b_valid && req.b_ready) begin
            b_hs_cnt++;
            if (b_q.size() > 0) void'(b_q.pop_front());
        end
        if (req.w_valid && resp.w_ready) begin
            w_hs_cnt++;
            if (req.w.last) begin
                check("w_last_has_aw", aw_q.size() > 0, 1);
                if (aw_q.size() > 0) b_q.push_back(aw_q.pop_front());
            end
        end
        if (req.aw_valid && resp.aw_ready) aw_q.push_back(req.aw.id);
        if (req.ar_valid && resp.ar_ready) begin
            for (int i = 0; i <= int'(req.ar.len); i++) begin
                r_q.push_back('{id: req.ar.id, last: (i == int'(req.ar.len))});
            end
        end
        r_stall_prev = resp.r_valid && !req.r_ready;
        r_prev       = '{id: resp.r.id, last: resp.r.last};
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            req.b_ready = 1'($urandom_range(0, 1));
            req.r_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic aw_txn(input logic [IdWidth-1:0] id);
        int n = 0;
        req.aw      = '0;
        req.aw.id   = id;
        req.aw.addr = $urandom;
        req.aw.len  = 8'($urandom);
        req.aw.atop = 6'($urandom);
        req.aw_valid = 1'b1;
        while (!resp.aw_ready && n < 100) begin step(); n++; end
        check("aw_accept", resp.aw_ready, 1);
        step();
        req.aw_valid = 1'b0;
    endtask

    task automatic w_burst(input int beats);
        int n;
        for (int k = 0; k < beats; k++) begin
            req.w.data  = {$urandom, $urandom};
            req.w.strb  = '1;
            req.w.last  = (k == beats - 1);
            req.w_valid = 1'b1;
            n = 0;
            while (!resp.w_ready && n < 200) begin step(); n++; end
            check("w_accept", resp.w_ready, 1);
            step();
        end
        req.w_valid = 1'b0;
        req.w.last  = 1'b0;
    endtask

    task automatic ar_txn(input logic [IdWidth-1:0] id, input logic [7:0] len);
        int n = 0;
        req.ar      = '0;
        req.ar.id   = id;
        req.ar.len  = len;
        req.ar.addr = $urandom;
        req.ar_valid = 1'b1;
        while (!resp.ar_ready && n < 100) begin step(); n++; end
        check("ar_accept", resp.ar_ready, 1);
        step();
        req.ar_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rand_rdy    = 1'b0;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        while ((r_q.size() > 0 || b_q.size() > 0) && n < 2000) begin step(); n++; end
        check("drain_r", r_q.size(), 0);
        check("drain_b", b_q.size(), 0);
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, b0, r0, n;
        req   = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            check("rst_aw_ready", resp.aw_ready, 1);
            check("rst_ar_ready", resp.ar_ready, 1);
            check("rst_w_ready", resp.w_ready, 0);
            check("rst_b_valid", resp.b_valid, 0);
            check("rst_r_valid", resp.r_valid, 0);
            step();
        end

        // Single write burst, B one cycle after the last W
        req.b_ready = 1'b1;
        w0 = w_hs_cnt;
        b0 = b_hs_cnt;
        aw_txn(4'd3);
        w_burst(4);
        check("b_after_last_w_valid", resp.b_valid, 1);
        check("b_after_last_w_id", resp.b.id, 3);
        check("b_after_last_w_resp", resp.b.resp, RESP_CODE);
        step();
        check("w_hs_count", w_hs_cnt - w0, 4);
        check("b_hs_count", b_hs_cnt - b0, 1);

        // Read burst len=7 and first-beat latency
        req.r_ready = 1'b1;
        r0 = r_hs_cnt;
        ar_txn(4'd5, 8'd7);
        check("r_lat_t1", resp.r_valid, 0);
        step();
        check("r_lat_t2", resp.r_valid, 1);
        check("r_lat_id", resp.r.id, 5);
        drain();
        check("r_beats_len7", r_hs_cnt - r0, 8);

        // Five ARs stalled: four sit in the read FIFO, one is held by the FSM
        req.r_ready = 1'b0;
        for (int id = 1; id <= 5; id++) ar_txn(4'(id), 8'd0);
        check("ar_full", resp.ar_ready, 0);
        repeat (3) step();
        check("ar_full_held", resp.ar_ready, 0);
        check("r_held_valid", resp.r_valid, 1);
        check("r_held_id", resp.r.id, 1);
        r0 = r_hs_cnt;
        drain();
        check("r_beats_five", r_hs_cnt - r0, 5);
        check("ar_ready_after", resp.ar_ready, 1);

        // len=255 gives 256 beats
        r0 = r_hs_cnt;
        ar_txn(4'd7, 8'd255);
        drain();
        check("r_beats_len255", r_hs_cnt - r0, 256);

        // W arrives before AW
        w0 = w_hs_cnt;
        b0 = b_hs_cnt;
        req.w.data  = {$urandom, $urandom};
        req.w.last  = 1'b0;
        req.w_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("w_early_stall", resp.w_ready, 0);
            step();
        end
        check("w_early_no_hs", w_hs_cnt - w0, 0);
        aw_txn(4'd9);
        check("w_ready_after_aw", resp.w_ready, 1);
        w_burst(2);
        drain();
        check("w_early_hs", w_hs_cnt - w0, 2);
        check("w_early_b", b_hs_cnt - b0, 1);

        // Random traffic with random back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                aw_txn(4'($urandom));
                w_burst($urandom_range(1, 4));
            end else begin
                ar_txn(4'($urandom), 8'($urandom_range(0, 5)));
            end
        end
        drain();

        // Reset in the middle of a read burst (cnt_q == 3)
        req.r_ready = 1'b1;
        r0 = r_hs_cnt;
        ar_txn(4'd6, 8'd7);
        n = 0;
        while ((r_hs_cnt - r0) < 4 && n < 50) begin step(); n++; end
        check("pre_reset_beats", r_hs_cnt - r0, 4);
        req.r_ready = 1'b0;
        check("pre_reset_rvalid", resp.r_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_rvalid", resp.r_valid, 0);
        check("mid_reset_ar_ready", resp.ar_ready, 1);
        check("mid_reset_aw_ready", resp.aw_ready, 1);
        check("mid_reset_b_valid", resp.b_valid, 0);
        aw_q.delete();
        b_q.delete();
        r_q.delete();
        r_stall_prev = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("post_reset_rvalid", resp.r_valid, 0);
        req.r_ready = 1'b1;
        r0 = r_hs_cnt;
        ar_txn(4'd2, 8'd0);
        drain();
        check("post_reset_beats", r_hs_cnt - r0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
